// File: rtl/hex_ascii_fmt.sv
// hex_ascii_fmt: turns a binary value of up to MAX_BYTES bytes into lowercase
// ASCII hex characters, most-significant nibble first, with an optional line
// feed at the end. The output is a byte stream with a valid/ready handshake
// that feeds the UART TX byte input.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a request; in_ready=1, out_valid=0
// HEX   | presenting hex digits; cnt = digits still to be handshaken
// EOL   | presenting the trailing line feed (only when ADD_LF=1)

module hex_ascii_fmt #(
    parameter int MAX_BYTES = 16,
    parameter int ADD_LF    = 1,
    parameter int LEN_W     = $clog2(MAX_BYTES + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [8*MAX_BYTES-1:0] in_data,
    input  logic [LEN_W-1:0]       in_len,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [7:0]             out_byte,
    output logic                   busy
);

    localparam int W    = 8 * MAX_BYTES;
    localparam int SH_W = $clog2(W + 1);

    typedef enum logic [1:0] {
        IDLE,
        HEX,
        EOL
    } state_t;

    state_t           state_q, state_d;
    logic [W-1:0]     sr_q, sr_d;
    logic [LEN_W:0]   cnt_q, cnt_d;
    logic             out_valid_q, out_valid_d;
    logic [7:0]       out_byte_q, out_byte_d;

    logic [LEN_W-1:0] len_clamp;
    logic [SH_W-1:0]  shamt;
    logic [W-1:0]     aligned;
    logic [W-1:0]     sr_next;

    // Lowercase ASCII for one nibble: '0'..'9' then 'a'..'f'.
    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
    endfunction

    // Clamp the length and left-align the printed bytes at the top of the
    // shift register so the first digit is always sr[W-1:W-4]. A length of
    // zero shifts by the full width and leaves the register clear.
    always_comb begin
        len_clamp = (in_len > LEN_W'(MAX_BYTES)) ? LEN_W'(MAX_BYTES) : in_len;
        shamt     = SH_W'(W) - SH_W'({len_clamp, 3'b000});
        aligned   = in_data << shamt;
        sr_next   = sr_q << 4;
    end

    // Next-state logic. Characters are computed one cycle ahead into the
    // out_byte register so the output never depends combinationally on
    // out_ready, and a handshake immediately loads the following character.
    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_byte_d  = out_byte_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sr_d  = aligned;
                    cnt_d = {len_clamp, 1'b0};
                    if (len_clamp != '0) begin
                        state_d     = HEX;
                        out_valid_d = 1'b1;
                        out_byte_d  = hex_char(aligned[W-1 -: 4]);
                    end else if (ADD_LF != 0) begin
                        state_d     = EOL;
                        out_valid_d = 1'b1;
                        out_byte_d  = 8'h0A;
                    end
                end
            end
            HEX: begin
                if (out_ready) begin
                    sr_d  = sr_next;
                    cnt_d = cnt_q - (LEN_W + 1)'(1);
                    if (cnt_q == (LEN_W + 1)'(1)) begin
                        if (ADD_LF != 0) begin
                            state_d    = EOL;
                            out_byte_d = 8'h0A;
                        end else begin
                            state_d     = IDLE;
                            out_valid_d = 1'b0;
                        end
                    end else begin
                        out_byte_d = hex_char(sr_next[W-1 -: 4]);
                    end
                end
            end
            EOL: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset drops any partially printed value.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sr_q        <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_byte_q  <= 8'h00;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_byte_q  <= out_byte_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign out_byte  = out_byte_q;

endmodule

// File: tb/tb_hex_ascii_fmt.sv
// Directed bench for hex_ascii_fmt: one instance with the line feed enabled,
// a second with it disabled for the no-terminator cases.

module tb_hex_ascii_fmt;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_valid_n;
    logic [127:0] in_data;
    logic [4:0]   in_len;
    logic         out_ready, out_ready_n;
    logic         in_ready, out_valid, busy;
    logic [7:0]   out_byte;
    logic         in_ready_n, out_valid_n, busy_n;
    logic [7:0]   out_byte_n;

    int n_chk  = 0;
    int n_pass = 0;
    byte q[$];

    localparam logic [127:0] FULL = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] ONE  = {{15{8'hFF}}, 8'hA5};

    hex_ascii_fmt #(.MAX_BYTES(16), .ADD_LF(1)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_len(in_len),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_byte(out_byte), .busy(busy)
    );

    hex_ascii_fmt #(.MAX_BYTES(16), .ADD_LF(0)) dut_n (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_n), .in_ready(in_ready_n),
        .in_data(in_data), .in_len(in_len),
        .out_valid(out_valid_n), .out_ready(out_ready_n),
        .out_byte(out_byte_n), .busy(busy_n)
    );

    always #5 clk = ~clk;

    // Record every byte the downstream would take (sampled mid-low-phase,
    // after the driver has settled out_ready for the coming edge).
    always @(negedge clk) begin
        #2;
        if (!rst && out_valid && out_ready) q.push_back(out_byte);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic send(input logic [127:0] d, input logic [4:0] l);
        chk("accept_rdy", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_data  = d;
        in_len   = l;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Expects the characters of s back-to-back (out_ready held high),
    // optionally a line feed, then the idle state on the following cycle.
    task automatic expect_stream(input string tag, input string s, input bit lf);
        for (int i = 0; i < s.len(); i++) begin
            chk({tag, "_vld"}, {31'd0, out_valid}, 32'd1);
            chk({tag, "_chr"}, {24'd0, out_byte}, {24'd0, s[i]});
            @(negedge clk);
        end
        if (lf) begin
            chk({tag, "_lf_vld"}, {31'd0, out_valid}, 32'd1);
            chk({tag, "_lf"}, {24'd0, out_byte}, 32'h0A);
            @(negedge clk);
        end
        chk({tag, "_end_rdy"}, {31'd0, in_ready}, 32'd1);
        chk({tag, "_end_vld"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        string full_s;
        byte   bp_exp[6];
        bit    bp_rdy[6];
        full_s = "0123456789abcdeffedcba9876543210";
        bp_exp = '{8'h61, 8'h61, 8'h61, 8'h35, 8'h35, 8'h0A};
        bp_rdy = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

        rst = 1'b1; in_valid = 1'b0; in_valid_n = 1'b0;
        in_data = '0; in_len = '0; out_ready = 1'b1; out_ready_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_byte", {24'd0, out_byte}, 32'h00);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Full-width value, no backpressure.
        q.delete();
        send(FULL, 5'd16);
        chk("full_busy", {31'd0, busy}, 32'd1);
        chk("full_in_ready_low", {31'd0, in_ready}, 32'd0);
        expect_stream("full", full_s, 1'b1);
        chk("full_count", q.size(), 33);

        // Single byte, upper bytes must be ignored.
        q.delete();
        send(ONE, 5'd1);
        expect_stream("one", "a5", 1'b1);
        chk("one_count", q.size(), 3);

        // Backpressure on the single-byte request.
        q.delete();
        send(ONE, 5'd1);
        for (int k = 0; k < 6; k++) begin
            chk("bp_vld", {31'd0, out_valid}, 32'd1);
            chk("bp_chr", {24'd0, out_byte}, {24'd0, bp_exp[k]});
            out_ready = bp_rdy[k];
            @(negedge clk);
        end
        out_ready = 1'b1;
        chk("bp_end_rdy", {31'd0, in_ready}, 32'd1);
        chk("bp_count", q.size(), 3);
        if (q.size() == 3) begin
            chk("bp_q0", {24'd0, q[0]}, 32'h61);
            chk("bp_q1", {24'd0, q[1]}, 32'h35);
            chk("bp_q2", {24'd0, q[2]}, 32'h0A);
        end

        // Zero length with line feed.
        q.delete();
        send(FULL, 5'd0);
        expect_stream("zero_lf", "", 1'b1);
        chk("zero_lf_count", q.size(), 1);

        // Zero length without line feed: request consumed, nothing emitted.
        in_valid_n = 1'b1; in_data = FULL; in_len = 5'd0;
        @(negedge clk);
        in_valid_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("zero_nolf_rdy", {31'd0, in_ready_n}, 32'd1);
            chk("zero_nolf_vld", {31'd0, out_valid_n}, 32'd0);
            @(negedge clk);
        end

        // No-line-feed instance still prints digits and returns to idle.
        in_valid_n = 1'b1; in_data = ONE; in_len = 5'd1;
        @(negedge clk);
        in_valid_n = 1'b0;
        chk("nolf_c0", {24'd0, out_byte_n}, 32'h61);
        chk("nolf_v0", {31'd0, out_valid_n}, 32'd1);
        @(negedge clk);
        chk("nolf_c1", {24'd0, out_byte_n}, 32'h35);
        @(negedge clk);
        chk("nolf_end_vld", {31'd0, out_valid_n}, 32'd0);
        chk("nolf_end_rdy", {31'd0, in_ready_n}, 32'd1);

        // Oversized length clamps to 16 bytes.
        q.delete();
        send(FULL, 5'd31);
        expect_stream("clamp", full_s, 1'b1);
        chk("clamp_count", q.size(), 33);

        // Reset after the fifth character has been taken.
        q.delete();
        send(FULL, 5'd16);
        for (int i = 0; i < 5; i++) begin
            chk("mid_chr", {24'd0, out_byte}, {24'd0, full_s[i]});
            @(negedge clk);
        end
        chk("mid_sixth", {24'd0, out_byte}, 32'h35);
        rst = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        chk("mid_rst_vld", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_rdy", {31'd0, in_ready}, 32'd1);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("mid_count", q.size(), 5);
        q.delete();
        send({{15{8'h00}}, 8'h3C}, 5'd1);
        expect_stream("post_rst", "3c", 1'b1);
        chk("post_rst_count", q.size(), 3);

        // A request pulsed during HEX is ignored.
        q.delete();
        send(ONE, 5'd1);
        in_valid = 1'b1; in_data = {{15{8'h00}}, 8'h3C}; in_len = 5'd1;
        chk("ign_c0", {24'd0, out_byte}, 32'h61);
        @(negedge clk);
        in_valid = 1'b0;
        chk("ign_c1", {24'd0, out_byte}, 32'h35);
        @(negedge clk);
        chk("ign_lf", {24'd0, out_byte}, 32'h0A);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk("ign_idle_vld", {31'd0, out_valid}, 32'd0);
            @(negedge clk);
        end
        chk("ign_count", q.size(), 3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
